alu_arbiter: RTL and testbench

Two-requester round-robin arbiter and sequencer for the shared 64-bit ALU (`alu`). It accepts operations from two requester ports over valid/ready handshakes and grants one at a time. It registers the operands into the ALU, allows a full cycle for the combinational ALU to settle, and returns result plus flags to the owning requester over a second valid/ready handshake. It sits between the datapath issue logic and the single `alu` instance, which it instantiates internally.

---
 rtl/alu_arbiter.sv | 165 ++++++++++++++++
 tb/tb_alu_arbiter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester round-robin arbiter sequencing operations through one shared 64-bit ALU
//
// Ports:
//   clk, reset_n                      clock, asynchronous active-low reset
//   req_valid[1:0] / req_ready[1:0]   per-requester issue handshake (req_ready is the one-hot grant)
//   req{0,1}_a, req{0,1}_b, req{0,1}_cntrl   operands and opcode for each requester
//   resp_valid[1:0] / resp_ready[1:0] one-hot response handshake to the owning requester
//   resp_result, resp_flags, resp_err registered ALU response ({n, z, v, c} flags)
//   busy                              high whenever an operation is in flight
//
// alu: combinational 64-bit ALU.
//   Opcodes: 000 PASS_B, 010 ADD, 011 SUB, 100 AND, 101 OR, 110 XOR.
//   001 and 111 are illegal: err=1, result=0, flags=0.
module alu (
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  logic [2:0]  cntrl,
  output logic [63:0] result,
  output logic [3:0]  flags,
  output logic        err
);
  logic        arith;
  logic        sub;
  logic        ovf;
  logic [63:0] b_x;
  logic [64:0] sum;
  always_comb begin
    sub    = cntrl == 3'b011;
    arith  = cntrl[2:1] == 2'b01;
    err    = cntrl == 3'b001 || cntrl == 3'b111;
    // one adder serves both ADD and SUB: subtract as a + ~b + 1, so carry_out means "no borrow"
    b_x    = sub ? ~b : b;
    sum    = {1'b0, a} + {1'b0, b_x} + {64'd0, sub};
    ovf    = arith && (a[63] == b_x[63]) && (sum[63] != a[63]);
    result = cntrl == 3'b000 ? b :
             arith           ? sum[63:0] :
             cntrl == 3'b100 ? a & b :
             cntrl == 3'b101 ? a | b :
             cntrl == 3'b110 ? a ^ b : 64'd0;
    flags  = err ? 4'd0 : {result[63], result == 64'd0, ovf, arith && sum[64]};
  end
endmodule

module alu_arbiter #(
  parameter logic PRIORITY_INIT = 1'b0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [63:0] req0_a,
  input  logic [63:0] req0_b,
  input  logic [2:0]  req0_cntrl,
  input  logic [63:0] req1_a,
  input  logic [63:0] req1_b,
  input  logic [2:0]  req1_cntrl,
  output logic [1:0]  resp_valid,
  input  logic [1:0]  resp_ready,
  output logic [63:0] resp_result,
  output logic [3:0]  resp_flags,
  output logic        resp_err,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t      state_q, state_d;
  logic        ptr_q, ptr_d;
  logic        owner_q, owner_d;
  logic [63:0] a_q, a_d;
  logic [63:0] b_q, b_d;
  logic [2:0]  cntrl_q, cntrl_d;
  logic [1:0]  resp_valid_q, resp_valid_d;
  logic [63:0] result_q, result_d;
  logic [3:0]  flags_q, flags_d;
  logic        err_q, err_d;
  logic [1:0]  grant;
  logic        g;
  logic [63:0] alu_result;
  logic [3:0]  alu_flags;
  logic        alu_err;

  alu u_alu (
    .a      (a_q),
    .b      (b_q),
    .cntrl  (cntrl_q),
    .result (alu_result),
    .flags  (alu_flags),
    .err    (alu_err)
  );

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    owner_d      = owner_q;
    a_d          = a_q;
    b_d          = b_q;
    cntrl_d      = cntrl_q;
    resp_valid_d = resp_valid_q;
    result_d     = result_q;
    flags_d      = flags_q;
    err_d        = err_q;
    grant        = 2'b00;
    g            = 1'b0;
    if (state_q == IDLE)
      grant = req_valid[ptr_q]  ? (ptr_q ? 2'b10 : 2'b01) :
              req_valid[!ptr_q] ? (ptr_q ? 2'b01 : 2'b10) : 2'b00;
    case (state_q)
      IDLE: if (grant != 2'b00) begin
        g       = grant[1];
        a_d     = g ? req1_a : req0_a;
        b_d     = g ? req1_b : req0_b;
        cntrl_d = g ? req1_cntrl : req0_cntrl;
        owner_d = g;
        ptr_d   = !g;
        state_d = EXEC;
      end
      // the operand registers have driven the ALU for a full cycle, so its outputs are settled here
      EXEC: begin
        result_d     = alu_result;
        flags_d      = alu_flags;
        err_d        = alu_err;
        resp_valid_d = owner_q ? 2'b10 : 2'b01;
        state_d      = RESP;
      end
      RESP: if (resp_ready[owner_q]) begin
        resp_valid_d = 2'b00;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      ptr_q        <= PRIORITY_INIT;
      owner_q      <= 1'b0;
      a_q          <= 64'd0;
      b_q          <= 64'd0;
      cntrl_q      <= 3'd0;
      resp_valid_q <= 2'b00;
      result_q     <= 64'd0;
      flags_q      <= 4'd0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      owner_q      <= owner_d;
      a_q          <= a_d;
      b_q          <= b_d;
      cntrl_q      <= cntrl_d;
      resp_valid_q <= resp_valid_d;
      result_q     <= result_d;
      flags_q      <= flags_d;
      err_q        <= err_d;
    end
  end

  // the state register already sits in IDLE during reset, so the grant is masked explicitly
  assign req_ready   = reset_n ? grant : 2'b00;
  assign resp_valid  = resp_valid_q;
  assign resp_result = result_q;
  assign resp_flags  = flags_q;
  assign resp_err    = err_q;
  assign busy        = state_q != IDLE;
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: randomized scoreboard bench for alu_arbiter against a behavioural reference model
module tb_alu_arbiter;
  localparam int PI = 0;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  req_valid = 2'b00;
  logic [1:0]  req_ready;
  logic [63:0] req0_a = 64'd0, req0_b = 64'd0, req1_a = 64'd0, req1_b = 64'd0;
  logic [2:0]  req0_cntrl = 3'd0, req1_cntrl = 3'd0;
  logic [1:0]  resp_valid;
  logic [1:0]  resp_ready = 2'b00;
  logic [63:0] resp_result;
  logic [3:0]  resp_flags;
  logic        resp_err;
  logic        busy;
  logic        rnd_done = 1'b0;

  typedef struct { logic [63:0] r; logic [3:0] f; logic e; int o; } exp_t;
  exp_t q[$];
  int   total = 0, bad = 0, cyc = 0, pend = 0, rise = 0, ptr_m = PI;
  int   acc_cnt[2] = '{0, 0};
  int   waitc[2]   = '{0, 0};

  always #5 clk = ~clk;

  alu_arbiter #(.PRIORITY_INIT(1'b0)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_cntrl(req0_cntrl),
    .req1_a(req1_a), .req1_b(req1_b), .req1_cntrl(req1_cntrl),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_result(resp_result), .resp_flags(resp_flags), .resp_err(resp_err),
    .busy(busy)
  );

  function automatic exp_t model(input logic [63:0] a, input logic [63:0] b, input logic [2:0] c, input int o);
    exp_t x;
    logic [64:0] s;
    x.o = o;
    x.e = c == 3'b001 || c == 3'b111;
    x.r = 64'd0;
    x.f = 4'd0;
    if (!x.e) begin
      if (c == 3'd0) x.r = b;
      else if (c == 3'd2) x.r = a + b;
      else if (c == 3'd3) x.r = a - b;
      else if (c == 3'd4) x.r = a & b;
      else if (c == 3'd5) x.r = a | b;
      else x.r = a ^ b;
      x.f[3] = x.r[63];
      x.f[2] = x.r == 64'd0;
      if (c == 3'd2) begin
        s = {a[63], a} + {b[63], b};
        x.f[1] = s[64] != s[63];
        x.f[0] = (a + b) < a;
      end
      if (c == 3'd3) begin
        s = {a[63], a} - {b[63], b};
        x.f[1] = s[64] != s[63];
        x.f[0] = a >= b;
      end
    end
    return x;
  endfunction

  function automatic logic [1:0] oh(input int i);
    return i != 0 ? 2'b10 : 2'b01;
  endfunction

  task automatic chk(input string n, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    logic [1:0] gnt, erv;
    int g;
    cyc++;
    if (!reset_n) begin
      chk("reset_outputs", {req_ready, resp_valid, resp_result, resp_flags, resp_err, busy}, 128'd0);
      pend = 0;
      ptr_m = PI;
      q.delete();
      waitc = '{0, 0};
    end else begin
      gnt = pend != 0 ? 2'b00 :
            req_valid[ptr_m] ? oh(ptr_m) :
            req_valid[1 - ptr_m] ? oh(1 - ptr_m) : 2'b00;
      erv = (pend != 0 && cyc >= rise) ? oh(q[0].o) : 2'b00;
      chk("req_ready", req_ready, gnt);
      chk("resp_valid", resp_valid, erv);
      chk("busy", busy, pend != 0);
      if (erv != 2'b00) begin
        chk("resp_result", resp_result, q[0].r);
        chk("resp_flags", resp_flags, q[0].f);
        chk("resp_err", resp_err, q[0].e);
        if (resp_ready[q[0].o]) begin
          void'(q.pop_front());
          pend = 0;
        end
      end
      if (gnt != 2'b00) begin
        g = gnt[1] ? 1 : 0;
        q.push_back(g != 0 ? model(req1_a, req1_b, req1_cntrl, 1) : model(req0_a, req0_b, req0_cntrl, 0));
        pend = 1;
        rise = cyc + 2;
        ptr_m = 1 - g;
        acc_cnt[g]++;
      end
      for (int i = 0; i < 2; i++) begin
        if (req_valid[i] && !gnt[i]) begin
          waitc[i]++;
          if (waitc[i] > 60) begin
            total++;
            bad++;
            $display("FAIL accept_timeout req%0d: waited %0d cycles, required at most 60", i, waitc[i]);
            waitc[i] = 0;
          end
        end else waitc[i] = 0;
      end
    end
  end

  task automatic drive(input int i, input logic [63:0] a, input logic [63:0] b, input logic [2:0] c);
    int c0;
    if (i == 0) begin
      req0_a = a; req0_b = b; req0_cntrl = c;
    end else begin
      req1_a = a; req1_b = b; req1_cntrl = c;
    end
    c0 = acc_cnt[i];
    req_valid[i] = 1'b1;
    for (int n = 0; n < 80 && acc_cnt[i] == c0; n++) begin
      @(posedge clk);
      #1;
    end
    req_valid[i] = 1'b0;
  endtask

  function automatic logic [63:0] pick();
    int k;
    k = $urandom_range(0, 4);
    return k == 0 ? 64'd0 : k == 1 ? '1 : k == 2 ? 64'h8000_0000_0000_0000 :
           k == 3 ? 64'h7FFF_FFFF_FFFF_FFFF : {$urandom, $urandom};
  endfunction

  task automatic rand_req(input int i);
    int gap;
    repeat (20) begin
      gap = $urandom_range(0, 3);
      for (int n = 0; n < gap; n++) begin
        @(posedge clk);
        #1;
      end
      drive(i, pick(), pick(), 3'($urandom_range(0, 7)));
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    resp_ready = 2'b11;
    fork
      begin drive(0, 64'd5, 64'd5, 3'b011); drive(0, 64'd5, 64'd5, 3'b011); end
      begin drive(1, 64'hF0, 64'hFF, 3'b110); drive(1, 64'hF0, 64'hFF, 3'b110); end
    join
    drive(0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 3'b010);
    repeat (4) @(posedge clk);
    #1 resp_ready = 2'b00;
    fork
      drive(0, 64'hAAAA, 64'h0F0F, 3'b101);
      begin @(posedge clk); #1; drive(1, 64'd0, 64'h55, 3'b000); end
      begin
        repeat (9) @(posedge clk);
        #1 resp_ready = 2'b10;
        repeat (3) @(posedge clk);
        #1 resp_ready = 2'b01;
      end
    join
    repeat (2) @(posedge clk);
    #1 resp_ready = 2'b11;
    repeat (3) @(posedge clk);
    #1;
    drive(1, '1, '1, 3'b111);
    drive(0, 64'd3, 64'd6, 3'b100);
    repeat (4) @(posedge clk);
    #1;
    drive(0, 64'd1, 64'd2, 3'b010);
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    fork
      drive(0, 64'd0, 64'h1234, 3'b000);
      drive(1, 64'd7, 64'd9, 3'b010);
    join
    repeat (4) @(posedge clk);
    #1;
    fork
      begin
        fork
          rand_req(0);
          rand_req(1);
        join
        rnd_done = 1'b1;
      end
      while (!rnd_done) begin
        @(posedge clk);
        #1 resp_ready = 2'($urandom_range(0, 3));
      end
    join
    resp_ready = 2'b11;
    repeat (10) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
